// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parameterised UART transmitter:
//   - parity-mode constants (NONE / ODD / EVEN)
//   - transmitter FSM state type
//   - baud divisor helper (clock cycles per bit, truncating division)
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Cycles per bit; any remainder is dropped, so the real baud rate is
  // slightly above the nominal one when CLK_PERIOD is not an exact multiple.
  function automatic int calc_baud_div(input int clk_hz, input int bps);
    return clk_hz / bps;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Small synchronous FIFO holding words waiting for transmission.
// A push while full and a pop while empty are ignored.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset, empties the FIFO
//   push_i       write push_data_i (ignored when full)
//   push_data_i  word to store
//   pop_i        drop the head entry (ignored when empty)
//   pop_data_o   head entry, valid while empty_o is 0
//   full_o       DEPTH entries held
//   empty_o      no entries held
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (AW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (AW + 1)'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
// Parameterised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits. Every bit lasts
// CLK_PERIOD/UART_BPS clock cycles.
//
// Build option
//   UART_TX_FIFO_EN  defined: accepted words queue in a 4-entry FIFO and
//                    frames run back to back; tx_ready = FIFO not full.
//                    undefined: one holding register; tx_ready only while
//                    idle with nothing held.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   tx_valid      tx_data holds a word to send
//   tx_data       payload, bits [DATA_BITS-1:0] are sent
//   tx_ready      a word is accepted on this edge if tx_valid is high
//   uart_txd      serial line, idle high, registered
//   uart_tx_busy  frame in progress or word pending
//
// FSM states
//   ST_IDLE   | line high, baud counter held at 0, waiting for a word
//   ST_START  | start bit (low)
//   ST_DATA   | data bits, LSB first, bit_idx_q counts them
//   ST_PARITY | parity bit (only reachable when PARITY != 0)
//   ST_STOP   | stop bits (high), bit_idx_q counts them
// ---------------------------------------------------------------------------
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_PERIOD = 100000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       uart_tx_busy
);

  localparam int BAUD_CNT_MAX = calc_baud_div(CLK_PERIOD, UART_BPS);
  localparam int CW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_CNT_MAX - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]    DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);

  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          par_bit_q;
  logic          txd_q;
  logic          ready_en_q;

  logic          baud_wrap;
  logic          accept;
  logic          word_avail;
  logic [7:0]    word_data;
  logic [7:0]    frame_word;
  logic          par_calc;
  logic          stop_done;
  logic          word_take;

  assign baud_wrap  = (cnt_q == CNT_LAST);
  assign cnt_d      = baud_wrap ? '0 : cnt_q + CW'(1);
  assign accept     = tx_valid && tx_ready;
  assign frame_word = word_data & DATA_MASK;
  assign par_calc   = (PARITY == PARITY_EVEN) ? ^frame_word : ~^frame_word;
  assign stop_done  = (state_q == ST_STOP) && baud_wrap && (bit_idx_q == STOP_LAST);
  // A pending word is consumed when a frame starts, either from idle or
  // straight out of the last stop bit.
  assign word_take  = word_avail && ((state_q == ST_IDLE) || stop_done);

  // tx_ready stays low during reset and for the edge that releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (4)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (accept),
    .push_data_i (tx_data),
    .pop_i       (word_take),
    .pop_data_o  (word_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign word_avail = !fifo_empty;
  assign tx_ready   = ready_en_q && !fifo_full;
`else
  logic       held_q;
  logic [7:0] hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= 1'b0;
      hold_q <= '0;
    end else if (accept) begin
      held_q <= 1'b1;
      hold_q <= tx_data;
    end else if (word_take) begin
      held_q <= 1'b0;
    end
  end

  assign word_avail = held_q;
  assign word_data  = hold_q;
  assign tx_ready   = ready_en_q && (state_q == ST_IDLE) && !held_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          txd_q     <= 1'b1;
          if (word_avail) begin
            state_q   <= ST_START;
            txd_q     <= 1'b0;
            shift_q   <= frame_word;
            par_bit_q <= par_calc;
          end
        end
        ST_START: begin
          cnt_q <= cnt_d;
          if (baud_wrap) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
          end
        end
        ST_DATA: begin
          cnt_q <= cnt_d;
          if (baud_wrap) begin
            if (bit_idx_q == DATA_LAST) begin
              bit_idx_q <= '0;
              if (PARITY != PARITY_NONE) begin
                state_q <= ST_PARITY;
                txd_q   <= par_bit_q;
              end else begin
                state_q <= ST_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          cnt_q <= cnt_d;
          if (baud_wrap) begin
            state_q   <= ST_STOP;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
          end
        end
        ST_STOP: begin
          cnt_q <= cnt_d;
          if (baud_wrap) begin
            if (bit_idx_q == STOP_LAST) begin
              bit_idx_q <= '0;
              if (word_avail) begin
                state_q   <= ST_START;
                txd_q     <= 1'b0;
                shift_q   <= frame_word;
                par_bit_q <= par_calc;
              end else begin
                state_q <= ST_IDLE;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          bit_idx_q <= '0;
          txd_q     <= 1'b1;
        end
      endcase
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = (state_q != ST_IDLE) || word_avail;

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  localparam int CPB = 16;
  localparam int NI  = 4;

  typedef struct {
    logic [11:0] bits;
    int          len;
    logic [7:0]  word;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic       valid [NI];
  logic [7:0] data  [NI];
  logic       ready [NI];
  logic       txd   [NI];
  logic       busy  [NI];

  frame_t sb_q [$];
  int     n_cmp;
  int     n_err;
  int     frames_done;
  int     last_gap;
  int     mon_sel;
  logic   mon_en;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 5N2 -- all at 16 cycles per bit
  uart_tx_param #(.CLK_PERIOD(1600), .UART_BPS(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[0]), .tx_data(data[0]),
    .tx_ready(ready[0]), .uart_txd(txd[0]), .uart_tx_busy(busy[0]));
  uart_tx_param #(.CLK_PERIOD(1600), .UART_BPS(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[1]), .tx_data(data[1]),
    .tx_ready(ready[1]), .uart_txd(txd[1]), .uart_tx_busy(busy[1]));
  uart_tx_param #(.CLK_PERIOD(1600), .UART_BPS(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[2]), .tx_data(data[2]),
    .tx_ready(ready[2]), .uart_txd(txd[2]), .uart_tx_busy(busy[2]));
  uart_tx_param #(.CLK_PERIOD(1600), .UART_BPS(100), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[3]), .tx_data(data[3]),
    .tx_ready(ready[3]), .uart_txd(txd[3]), .uart_tx_busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_db(input int s);
    return (s == 3) ? 5 : 8;
  endfunction
  function automatic int cfg_par(input int s);
    return (s == 1) ? 2 : (s == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_sb(input int s);
    return (s == 3) ? 2 : 1;
  endfunction

  function automatic frame_t build_frame(input int s, input logic [7:0] d);
    frame_t f;
    int     k;
    logic   p;
    f.bits = '1;
    f.word = d;
    f.bits[0] = 1'b0;
    k = 1;
    p = 1'b0;
    for (int i = 0; i < cfg_db(s); i++) begin
      f.bits[k] = d[i];
      p = p ^ d[i];
      k++;
    end
    if (cfg_par(s) == 2) begin
      f.bits[k] = p;
      k++;
    end else if (cfg_par(s) == 1) begin
      f.bits[k] = ~p;
      k++;
    end
    for (int i = 0; i < cfg_sb(s); i++) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.len = k;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for ready, accepts on the following edge, returns #1 after it.
  task automatic send(input int s, input logic [7:0] d, input bit expect_frame);
    int n;
    n = 0;
    @(negedge clk);
    valid[s] = 1'b1;
    data[s]  = d;
    while (ready[s] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("send_timeout", 32'(ready[s]), 32'd1);
      valid[s] = 1'b0;
    end else begin
      if (expect_frame) sb_q.push_back(build_frame(s, d));
      @(posedge clk);
      #1;
      valid[s] = 1'b0;
      data[s]  = ~d;
    end
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (frames_done < target) chk("frame_timeout", 32'(frames_done), 32'(target));
  endtask

  task automatic idle_check(input int s, input string tag);
    @(negedge clk);
    chk({tag, "_txd"},   32'(txd[s]),   32'd1);
    chk({tag, "_busy"},  32'(busy[s]),  32'd0);
    chk({tag, "_ready"}, 32'(ready[s]), 32'd1);
  endtask

  // Scoreboard consumer: decodes each frame on the selected line and checks
  // every bit for its full 16 cycles against the queued expectation.
  initial begin : monitor
    frame_t f;
    logic   prev;
    logic   aborted;
    logic   ok;
    logic   obs;
    logic   rdy_bad;
    int     idle;
    prev = 1'b1;
    idle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b1;
        idle = 0;
      end else if (mon_en && prev && txd[mon_sel] === 1'b0) begin
        last_gap = idle;
        idle = 0;
        chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
        f.len = 0;
        f.word = '0;
        f.bits = '1;
        if (sb_q.size() != 0) f = sb_q.pop_front();
        aborted = 1'b0;
        for (int b = 0; b < f.len && !aborted; b++) begin
          ok = 1'b1;
          obs = f.bits[b];
          rdy_bad = 1'b0;
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!rst_n) aborted = 1'b1;
            if (ok && txd[mon_sel] !== f.bits[b]) begin
              ok = 1'b0;
              obs = txd[mon_sel];
            end
`ifndef UART_TX_FIFO_EN
            if (ready[mon_sel] !== 1'b0) rdy_bad = 1'b1;
`endif
          end
          if (!aborted)
            chk($sformatf("w%02h_bit%0d{rdy,txd}", f.word, b), {30'd0, rdy_bad, obs}, {31'd0, f.bits[b]});
        end
        frames_done++;
        prev = 1'b1;
      end else begin
        if (txd[mon_sel] === 1'b1) idle++;
        prev = txd[mon_sel];
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] pat [4];
    int base;
    n_cmp = 0;
    n_err = 0;
    frames_done = 0;
    last_gap = 0;
    mon_sel = 0;
    mon_en = 1'b1;
    rst_n = 1'b0;
    for (int s = 0; s < NI; s++) begin
      valid[s] = 1'b0;
      data[s]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < NI; s++) begin
      chk($sformatf("rst%0d_txd", s),   32'(txd[s]),   32'd1);
      chk($sformatf("rst%0d_busy", s),  32'(busy[s]),  32'd0);
      chk($sformatf("rst%0d_ready", s), 32'(ready[s]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 0; s < NI; s++) chk($sformatf("ready%0d_after_rst", s), 32'(ready[s]), 32'd1);

    // 8N1 0x55 with accept-to-start latency
    send(0, 8'h55, 1'b1);
    chk("lat_txd_at_accept", 32'(txd[0]), 32'd1);
    chk("lat_busy_at_accept", 32'(busy[0]), 32'd1);
`ifdef UART_TX_FIFO_EN
    chk("lat_ready_at_accept", 32'(ready[0]), 32'd1);
`else
    chk("lat_ready_at_accept", 32'(ready[0]), 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("lat_start_bit", 32'(txd[0]), 32'd0);
`ifndef UART_TX_FIFO_EN
    // valid while not ready must be ignored
    repeat (20) @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'hEE;
    repeat (40) @(negedge clk);
    valid[0] = 1'b0;
`endif
    wait_frames(1);
    idle_check(0, "idle_after_55");

    pat = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    for (int i = 0; i < 4; i++) begin
      base = frames_done;
      send(0, pat[i], 1'b1);
      wait_frames(base + 1);
      idle_check(0, $sformatf("idle_after_%02h", pat[i]));
    end

    // back-to-back burst, order preserved
    base = frames_done;
    send(0, 8'h11, 1'b1);
    send(0, 8'h22, 1'b1);
    send(0, 8'h33, 1'b1);
    send(0, 8'h44, 1'b1);
    send(0, 8'h55, 1'b1);
`ifdef UART_TX_FIFO_EN
    chk("fifo_full_ready", 32'(ready[0]), 32'd0);
    wait_frames(base + 1);
    for (int k = 2; k <= 5; k++) begin
      wait_frames(base + k);
      chk($sformatf("gap_before_frame%0d", k), 32'(last_gap), 32'd0);
    end
`else
    wait_frames(base + 5);
`endif
    idle_check(0, "idle_after_burst");
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // parity: even then odd, 0xA3 has four ones
    mon_sel = 1;
    base = frames_done;
    send(1, 8'hA3, 1'b1);
    wait_frames(base + 1);
    idle_check(1, "idle_even_a3");
    base = frames_done;
    send(1, 8'h07, 1'b1);
    wait_frames(base + 1);
    idle_check(1, "idle_even_07");
    mon_sel = 2;
    base = frames_done;
    send(2, 8'hA3, 1'b1);
    wait_frames(base + 1);
    idle_check(2, "idle_odd_a3");

    // 5 data bits, 2 stop bits; upper payload bits ignored
    mon_sel = 3;
    base = frames_done;
    send(3, 8'h1F, 1'b1);
    wait_frames(base + 1);
    idle_check(3, "idle_5n2_1f");
    base = frames_done;
    send(3, 8'hE5, 1'b1);
    wait_frames(base + 1);
    idle_check(3, "idle_5n2_e5");

    // reset in data bit 3
    mon_sel = 0;
    mon_en = 1'b0;
    send(0, 8'h3C, 1'b0);
    repeat (70) @(posedge clk);
    #3;
    chk("busy_before_rst", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd[0]), 32'd1);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_ready", 32'(ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_midrst", 32'(ready[0]), 32'd1);
    base = frames_done;
    send(0, 8'hC9, 1'b1);
    wait_frames(base + 1);
    idle_check(0, "idle_after_c9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
